// File: rtl/cdb_arb_pkg.sv
// cdb_arb_pkg: shared CDB payload type and ROB/PRF/arch register index widths
package cdb_arb_pkg;
  localparam int ROB_W = 6;
  localparam int PRF_W = 7;
  localparam int ARCH_W = 5;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [ROB_W-1:0]  rob_id;
    logic [PRF_W-1:0]  rd_phy;
    logic [ARCH_W-1:0] rd_arch;
    logic [XLEN-1:0]   rd_value;
  } cdb_entry_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: single-grant picker returning the first set req bit at or after start (wrapping); ports req/start in, found/idx out
module rr_picker #(
  parameter int N = 4,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(start) + i) % N]) begin
        found = 1'b1;
        idx = IW'((int'(start) + i) % N);
      end
  end
endmodule

// File: rtl/cdb_arb.sv
// cdb_arb: CDB arbiter, priority requester on port 0 then round-robin fill; ports clk/rst/flush, req_valid/req_entry in, req_ready out, registered cdb_valid/cdb_entry out
module cdb_arb
  import cdb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CDB_PORTS = 2,
  parameter int PRIO_REQ = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  cdb_entry_t [NUM_REQ-1:0]      req_entry,
  output logic [CDB_PORTS-1:0]          cdb_valid,
  output cdb_entry_t [CDB_PORTS-1:0]    cdb_entry
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [CDB_PORTS:0][NUM_REQ-1:0] avail;
  logic [CDB_PORTS-1:0] pick_v;
  logic [CDB_PORTS-1:0][IW-1:0] pick_idx;
  assign avail[0] = (rst || flush) ? '0 : req_valid;
  assign req_ready = avail[0] & ~avail[CDB_PORTS];
  genvar k;
  for (k = 0; k < CDB_PORTS; k++) begin : g_port
    // port 0 starts at the priority requester when it is valid, so it wins port 0
    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req  (avail[k]),
      .start((k == 0 && avail[0][PRIO_REQ]) ? IW'(PRIO_REQ) : rr_ptr),
      .found(pick_v[k]),
      .idx  (pick_idx[k])
    );
    assign avail[k+1] = avail[k] & ~(NUM_REQ'(pick_v[k]) << pick_idx[k]);
  end
  always_comb begin
    rr_nxt = rr_ptr;
    for (int p = 0; p < CDB_PORTS; p++)
      if (pick_v[p] && pick_idx[p] != IW'(PRIO_REQ))
        rr_nxt = IW'((int'(pick_idx[p]) + 1) % NUM_REQ);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= '0;
      cdb_entry <= '0;
      rr_ptr <= '0;
    end else begin
      cdb_valid <= pick_v;
      rr_ptr <= rr_nxt;
      for (int p = 0; p < CDB_PORTS; p++)
        cdb_entry[p] <= pick_v[p] ? req_entry[pick_idx[p]] : '0;
    end
  end
endmodule

// File: tb/tb_cdb_arb.sv
// tb_cdb_arb: directed vector table, hand sequence and randomized model check for cdb_arb
module tb_cdb_arb;
  import cdb_arb_pkg::*;
  localparam int N = 4;
  localparam int P = 2;
  localparam int PR = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  cdb_entry_t [N-1:0] ents;
  logic [P-1:0] cdb_valid;
  cdb_entry_t [P-1:0] cdb_entry;
  int checks = 0;
  int errors = 0;
  logic [N-1:0] got_rdy;
  int rr_m = 0;
  logic [N-1:0] m_rdy;
  int m_g [P];
  typedef struct {
    bit r;
    bit f;
    logic [3:0] v;
    logic [3:0] rdy;
    int p0;
    int p1;
  } vec_t;
  vec_t tbl [17];
  cdb_arb #(.NUM_REQ(N), .CDB_PORTS(P), .PRIO_REQ(PR)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_entry(ents), .cdb_valid(cdb_valid), .cdb_entry(cdb_entry)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // reference: priority requester first if valid, then scan from rr pointer skipping it
  task automatic model_step(input bit r, input bit f, input logic [N-1:0] v);
    int order[$];
    m_rdy = '0;
    for (int p = 0; p < P; p++) m_g[p] = -1;
    if (!r && !f) begin
      if (v[PR]) order.push_back(PR);
      for (int i = 0; i < N; i++) begin
        int id;
        id = (rr_m + i) % N;
        if (id != PR && v[id] && order.size() < P) order.push_back(id);
      end
    end
    foreach (order[j]) begin
      m_g[j] = order[j];
      m_rdy[order[j]] = 1'b1;
      if (order[j] != PR) rr_m = (order[j] + 1) % N;
    end
    if (r) rr_m = 0;
  endtask
  task automatic run_cycle(input bit r, input bit f, input logic [N-1:0] v);
    @(negedge clk);
    rst = r;
    flush = f;
    req_valid = v;
    #1;
    got_rdy = req_ready;
    @(posedge clk);
    #1;
  endtask
  task automatic check_outs(input string tag, input int g0, input int g1);
    int g [P];
    g[0] = g0;
    g[1] = g1;
    check({tag, " cdb_valid"}, 64'(cdb_valid), 64'({g1 >= 0, g0 >= 0}));
    for (int p = 0; p < P; p++)
      check($sformatf("%s cdb_entry%0d", tag, p), 64'(cdb_entry[p]), g[p] < 0 ? 64'd0 : 64'(ents[g[p]]));
  endtask
  function automatic cdb_entry_t rand_ent();
    cdb_entry_t e;
    e.rob_id = 6'($urandom);
    e.rd_phy = 7'($urandom);
    e.rd_arch = 5'($urandom);
    e.rd_value = $urandom;
    return e;
  endfunction
  initial begin
    logic [N-1:0] pend;
    bit r, f;
    tbl[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, -1, -1};
    tbl[1]  = '{1'b0, 1'b0, 4'b1101, 4'b0101,  0,  2};
    tbl[2]  = '{1'b0, 1'b0, 4'b1101, 4'b1001,  3,  0};
    tbl[3]  = '{1'b0, 1'b0, 4'b1101, 4'b1100,  2,  3};
    tbl[4]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, -1, -1};
    tbl[5]  = '{1'b0, 1'b0, 4'b0100, 4'b0100,  2, -1};
    tbl[6]  = '{1'b0, 1'b0, 4'b0010, 4'b0010,  1, -1};
    tbl[7]  = '{1'b0, 1'b0, 4'b1001, 4'b1001,  3,  0};
    tbl[8]  = '{1'b0, 1'b0, 4'b1111, 4'b0110,  1,  2};
    tbl[9]  = '{1'b0, 1'b0, 4'b1000, 4'b1000,  3, -1};
    tbl[10] = '{1'b0, 1'b1, 4'b0101, 4'b0000, -1, -1};
    tbl[11] = '{1'b0, 1'b0, 4'b0101, 4'b0101,  0,  2};
    tbl[12] = '{1'b0, 1'b0, 4'b1111, 4'b1010,  1,  3};
    tbl[13] = '{1'b1, 1'b0, 4'b1111, 4'b0000, -1, -1};
    tbl[14] = '{1'b0, 1'b0, 4'b1111, 4'b0011,  1,  0};
    tbl[15] = '{1'b0, 1'b0, 4'b0000, 4'b0000, -1, -1};
    tbl[16] = '{1'b1, 1'b1, 4'b1111, 4'b0000, -1, -1};
    for (int i = 0; i < N; i++)
      ents[i] = '{rob_id: 6'(10 + i), rd_phy: 7'(20 + i), rd_arch: 5'(i), rd_value: 32'hA000_0000 + i};
    ents[2] = '{rob_id: 6'd5, rd_phy: 7'd17, rd_arch: 5'd3, rd_value: 32'hDEAD_BEEF};
    for (int n = 0; n < 17; n++) begin
      model_step(tbl[n].r, tbl[n].f, tbl[n].v);
      run_cycle(tbl[n].r, tbl[n].f, tbl[n].v);
      check($sformatf("row%0d req_ready", n), 64'(got_rdy), 64'(tbl[n].rdy));
      check_outs($sformatf("row%0d", n), tbl[n].p0, tbl[n].p1);
    end
    // flush held two cycles with everyone valid, then release
    for (int n = 0; n < 2; n++) begin
      model_step(1'b0, 1'b1, 4'b1111);
      run_cycle(1'b0, 1'b1, 4'b1111);
      check($sformatf("hold_flush%0d req_ready", n), 64'(got_rdy), 64'd0);
      check_outs($sformatf("hold_flush%0d", n), -1, -1);
    end
    model_step(1'b0, 1'b0, 4'b1111);
    run_cycle(1'b0, 1'b0, 4'b1111);
    check("post_flush req_ready", 64'(got_rdy), 64'b0011);
    check_outs("post_flush", 1, 0);
    model_step(1'b0, 1'b0, 4'b1101);
    run_cycle(1'b0, 1'b0, 4'b1101);
    check("post_flush2 req_ready", 64'(got_rdy), 64'b1100);
    check_outs("post_flush2", 2, 3);
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          ents[i] = rand_ent();
        end
      r = ($urandom_range(0, 49) == 0);
      f = ($urandom_range(0, 9) == 0);
      model_step(r, f, pend);
      run_cycle(r, f, pend);
      check($sformatf("rand%0d req_ready", c), 64'(got_rdy), 64'(m_rdy));
      check_outs($sformatf("rand%0d", c), m_g[0], m_g[1]);
      pend &= ~m_rdy;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
